// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI frame arbiter.
package spi_pkg;

  localparam int SPI_FRAME_W         = 40;
  localparam int SPI_GAP_DEFAULT     = 4;
  localparam int SPI_TIMEOUT_DEFAULT = 200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } spi_arb_state_t;

  // Index width for a requester count; a single requester still needs one bit.
  function automatic int spi_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_frame_arbiter_if.sv
// Request/grant bus between the command sources, the arbiter and the frame shifter.
interface spi_frame_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = spi_pkg::SPI_FRAME_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        req_err;
  logic [DATA_W-1:0]         shf_data;
  logic                      shf_start;
  logic                      shf_done;
  logic                      spi_cs_n;

  // Environment side: requesters plus the shifter's completion pulse.
  modport master (
    output req_valid, req_data, shf_done,
    input  req_ready, req_done, req_err, shf_data, shf_start, spi_cs_n
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, shf_done,
    output req_ready, req_done, req_err, shf_data, shf_start, spi_cs_n
  );

endinterface

// File: rtl/spi_rr_pick.sv
// Round-robin pick: first valid requester at or after rr_ptr, wrapping.
module spi_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_valid
);

  // Scan upward from rr_ptr and keep only the first hit.
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx       = '0;
    grant_oh  = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!any_valid && req_valid[idx]) begin
        any_valid     = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/spi_frame_arbiter.sv
// Shares one SPI frame shifter between several requesters.
//
// state | meaning
// IDLE  | cs_n high, grant the round-robin winner and latch its frame
// SETUP | one cycle, cs_n low, start pulse to the shifter
// WAIT  | cs_n low, wait for shf_done under the watchdog
// GAP   | cs_n high for GAP_CYCLES before the next grant
module spi_frame_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_W     = SPI_FRAME_W,
  parameter int GAP_CYCLES = SPI_GAP_DEFAULT,
  parameter int TIMEOUT    = SPI_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_frame_arbiter_if.slave   bus,
  output logic                 busy
);

  localparam int          IDX_W     = spi_idx_w(NUM_REQ);
  localparam logic [7:0]  WDOG_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0]  GAP_LOAD  = 8'(GAP_CYCLES - 1);
  localparam bit          HAS_GAP   = (GAP_CYCLES != 0);

  spi_arb_state_t     state_q, state_d;
  logic [7:0]         wdog_q, wdog_d;
  logic [7:0]         gap_q, gap_d;
  logic [IDX_W-1:0]   rr_ptr_q, owner_q, ptr_next;
  logic [DATA_W-1:0]  frame_q, frame_sel;
  logic [NUM_REQ-1:0] grant_oh, owner_oh, done_q, err_q;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_valid;
  logic               accept, done_fire, err_fire;
  logic               start_q, cs_n_q, busy_q;

  spi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  // Ready is the only combinational output; held off while reset is asserted.
  assign bus.req_ready = (state_q == IDLE && !reset) ? grant_oh : '0;

  assign ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

  // Mux the winning requester's frame onto the latch input.
  always_comb begin
    frame_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) frame_sel = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // One-hot of the current owner for the done/err pulses.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  // Next-state logic, watchdog and gap counters; done beats expiry on the same cycle.
  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q;
    gap_d     = gap_q;
    accept    = 1'b0;
    done_fire = 1'b0;
    err_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = WAIT;
        wdog_d  = '0;
      end
      WAIT: begin
        if (bus.shf_done) begin
          done_fire = 1'b1;
        end else if (wdog_q == WDOG_LAST) begin
          err_fire = 1'b1;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
        if (done_fire || err_fire) begin
          state_d = HAS_GAP ? GAP : IDLE;
          gap_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wdog_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      gap_q   <= gap_d;
    end
  end

  // Frame latch, arbitration pointers and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      owner_q  <= '0;
      frame_q  <= '0;
      start_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      if (accept) begin
        frame_q  <= frame_sel;
        owner_q  <= grant_idx;
        rr_ptr_q <= ptr_next;
      end
      start_q <= accept;
      cs_n_q  <= !(state_d == SETUP || state_d == WAIT);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_fire ? owner_oh : '0;
      err_q   <= err_fire  ? owner_oh : '0;
    end
  end

  assign bus.shf_data  = frame_q;
  assign bus.shf_start = start_q;
  assign bus.spi_cs_n  = cs_n_q;
  assign bus.req_done  = done_q;
  assign bus.req_err   = err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Bench for spi_frame_arbiter: scenario tasks with a frame scoreboard.
module tb_spi_frame_arbiter;

  localparam int NREQ  = 2;
  localparam int DW    = 40;
  localparam int GAP_C = 4;
  localparam int TO_C  = 200;

  typedef struct {
    logic [DW-1:0] data;
    int            idx;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cs_high_run = 0;
  int   ptr_m = 0;
  exp_t exp_q[$];

  spi_frame_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bus();

  spi_frame_arbiter #(
    .NUM_REQ    (NREQ),
    .DATA_W     (DW),
    .GAP_CYCLES (GAP_C),
    .TIMEOUT    (TO_C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge, track the cs_n-high run, settle.
  task automatic step();
    @(negedge clk);
    if (bus.spi_cs_n === 1'b1) cs_high_run++;
    else cs_high_run = 0;
    #1;
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.shf_done = 1'b0;
    step();
    step();
    reset = 1'b0;
    ptr_m = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.shf_done = 1'b0;
    bus.req_data = {40'h22_2222_2222, 40'h11_1111_1111};
    bus.req_valid = '1;
    step();
    step();
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", bus.req_ready); end
    n_checks++; if (bus.spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", bus.spi_cs_n); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (bus.shf_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", bus.shf_start); end
    n_checks++; if (bus.shf_data !== 40'h0) begin n_fail++; $display("FAIL reset_shf_data: got %h expected 0", bus.shf_data); end
    n_checks++; if (bus.req_done !== 2'b00 || bus.req_err !== 2'b00) begin n_fail++; $display("FAIL reset_done_err: got %b/%b expected 00/00", bus.req_done, bus.req_err); end
    bus.req_valid = '0;
    step();
    reset = 1'b0;
    ptr_m = 0;
  endtask

  task automatic test_single();
    exp_t e;
    int   g;
    logic bad;
    e.idx = -1;
    bad = 1'b0;
    bus.req_data[DW-1:0] = 40'hA5_1234_5678;
    bus.req_valid = 2'b01;
    #1;
    g = pick(bus.req_valid, ptr_m);
    n_checks++; if (bus.req_ready !== oh(g)) begin n_fail++; $display("FAIL single_ready: got %b expected %b", bus.req_ready, oh(g)); end
    exp_q.push_back('{data: 40'hA5_1234_5678, idx: g});
    ptr_m = (g + 1) % NREQ;
    step();                                   // cycle 1
    bus.req_valid = 2'b00;
    bus.req_data[DW-1:0] = 40'h00_0BAD_0BAD;
    n_checks++; if (bus.spi_cs_n !== 1'b0 || bus.shf_start !== 1'b1) begin n_fail++; $display("FAIL single_setup: got cs_n=%b start=%b expected 0/1", bus.spi_cs_n, bus.shf_start); end
    n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL single_sb_empty: got 0 entries expected 1"); end
    else begin
      e = exp_q.pop_front();
      if (bus.shf_data !== e.data) begin n_fail++; $display("FAIL single_shf_data: got %h expected %h", bus.shf_data, e.data); end
    end
    for (int c = 2; c <= 45; c++) begin
      step();
      if (bus.spi_cs_n !== 1'b0 || bus.shf_start !== 1'b0 || bus.req_done !== 2'b00) bad = 1'b1;
      if (c == 45) bus.shf_done = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL single_wait_hold: got a cs_n/start/done glitch in cycles 2..45 expected none"); end
    step();                                   // cycle 46
    bus.shf_done = 1'b0;
    n_checks++; if (bus.req_done !== oh(e.idx)) begin n_fail++; $display("FAIL single_done: got %b expected %b", bus.req_done, oh(e.idx)); end
    n_checks++; if (bus.spi_cs_n !== 1'b1 || bus.req_err !== 2'b00) begin n_fail++; $display("FAIL single_done_cs: got cs_n=%b err=%b expected 1/00", bus.spi_cs_n, bus.req_err); end
    n_checks++; if (bus.shf_data !== 40'hA5_1234_5678) begin n_fail++; $display("FAIL single_frame_hold: got %h expected a512345678", bus.shf_data); end
    step(); step(); step();                   // cycle 49
    n_checks++; if (busy !== 1'b1 || bus.req_done !== 2'b00) begin n_fail++; $display("FAIL single_gap: got busy=%b done=%b expected 1/00", busy, bus.req_done); end
    step();                                   // cycle 50
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle50: got busy=%b expected 0", busy); end
  endtask

  task automatic test_fairness();
    int   order [4] = '{0, 1, 0, 1};
    logic [DW-1:0] d0, d1;
    exp_t e;
    int   g, act, waited;
    do_reset();
    d0 = 40'hAA_0000_0001;
    d1 = 40'hBB_0000_0001;
    bus.req_data = {d1, d0};
    bus.req_valid = 2'b11;
    #1;
    for (int f = 0; f < 4; f++) begin
      waited = 0;
      while (bus.req_ready === 2'b00 && waited < 60) begin step(); waited++; end
      if (waited >= 60) begin
        n_checks++; n_fail++;
        $display("FAIL fair_grant_timeout: got no grant in 60 cycles expected grant %0d", f);
        break;
      end
      g = pick(bus.req_valid, ptr_m);
      act = (bus.req_ready === 2'b10) ? 1 : 0;
      n_checks++; if (bus.req_ready !== oh(g)) begin n_fail++; $display("FAIL fair_ready: got %b expected %b", bus.req_ready, oh(g)); end
      n_checks++; if (act != order[f]) begin n_fail++; $display("FAIL fair_order: got %0d expected %0d", act, order[f]); end
      if (f > 0) begin
        n_checks++; if (cs_high_run != GAP_C + 1) begin n_fail++; $display("FAIL fair_gap: got %0d cs_n-high cycles expected %0d", cs_high_run, GAP_C + 1); end
      end
      exp_q.push_back('{data: (g == 0) ? d0 : d1, idx: g});
      ptr_m = (g + 1) % NREQ;
      step();
      if (g == 0) begin d0 = d0 + 40'd1; bus.req_data[DW-1:0] = d0; end
      else begin d1 = d1 + 40'd1; bus.req_data[2*DW-1:DW] = d1; end
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL fair_sb_empty: got 0 entries expected 1"); e.idx = -1; end
      else begin
        e = exp_q.pop_front();
        if (bus.shf_start !== 1'b1 || bus.shf_data !== e.data) begin n_fail++; $display("FAIL fair_setup: got start=%b data=%h expected 1/%h", bus.shf_start, bus.shf_data, e.data); end
      end
      repeat (3 + f) step();
      bus.shf_done = 1'b1;
      step();
      bus.shf_done = 1'b0;
      n_checks++; if (bus.req_done !== oh(e.idx) || bus.req_err !== 2'b00) begin n_fail++; $display("FAIL fair_done: got done=%b err=%b expected %b/00", bus.req_done, bus.req_err, oh(e.idx)); end
    end
    bus.req_valid = 2'b00;
    repeat (GAP_C + 1) step();
  endtask

  task automatic test_timeout();
    exp_t e;
    int   g, elapsed;
    logic bad;
    bad = 1'b0;
    bus.req_data[2*DW-1:DW] = 40'hCC_DEAD_BEEF;
    bus.req_valid = 2'b10;
    #1;
    g = pick(bus.req_valid, ptr_m);
    n_checks++; if (bus.req_ready !== oh(g)) begin n_fail++; $display("FAIL to_ready: got %b expected %b", bus.req_ready, oh(g)); end
    exp_q.push_back('{data: 40'hCC_DEAD_BEEF, idx: g});
    ptr_m = (g + 1) % NREQ;
    step();
    bus.req_valid = 2'b00;
    e = exp_q.pop_front();
    n_checks++; if (bus.shf_data !== e.data) begin n_fail++; $display("FAIL to_shf_data: got %h expected %h", bus.shf_data, e.data); end
    step();                                   // first WAIT cycle
    elapsed = 0;
    while (bus.req_done === 2'b00 && bus.req_err === 2'b00 && elapsed < 300) begin
      if (bus.spi_cs_n !== 1'b0) bad = 1'b1;
      step();
      elapsed++;
    end
    n_checks++; if (elapsed != TO_C) begin n_fail++; $display("FAIL to_latency: got %0d cycles expected %0d", elapsed, TO_C); end
    n_checks++; if (bus.req_err !== oh(e.idx) || bus.req_done !== 2'b00) begin n_fail++; $display("FAIL to_err: got err=%b done=%b expected %b/00", bus.req_err, bus.req_done, oh(e.idx)); end
    n_checks++; if (bus.spi_cs_n !== 1'b1 || bad) begin n_fail++; $display("FAIL to_cs: got cs_n=%b early_rise=%b expected 1/0", bus.spi_cs_n, bad); end
    repeat (GAP_C) step();
  endtask

  task automatic test_coincide();
    exp_t e;
    int   g;
    logic bad;
    bad = 1'b0;
    bus.req_data[DW-1:0] = 40'hDD_0102_0304;
    bus.req_valid = 2'b01;
    #1;
    g = pick(bus.req_valid, ptr_m);
    n_checks++; if (bus.req_ready !== oh(g)) begin n_fail++; $display("FAIL co_ready: got %b expected %b", bus.req_ready, oh(g)); end
    exp_q.push_back('{data: 40'hDD_0102_0304, idx: g});
    ptr_m = (g + 1) % NREQ;
    step();
    bus.req_valid = 2'b00;
    e = exp_q.pop_front();
    n_checks++; if (bus.shf_data !== e.data) begin n_fail++; $display("FAIL co_shf_data: got %h expected %h", bus.shf_data, e.data); end
    step();                                   // first WAIT cycle
    repeat (TO_C - 1) step();                 // watchdog final cycle
    bus.shf_done = 1'b1;
    step();
    bus.shf_done = 1'b0;
    n_checks++; if (bus.req_done !== oh(e.idx) || bus.req_err !== 2'b00) begin n_fail++; $display("FAIL co_done_only: got done=%b err=%b expected %b/00", bus.req_done, bus.req_err, oh(e.idx)); end
    repeat (3) begin
      step();
      if (bus.req_err !== 2'b00 || bus.req_done !== 2'b00) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL co_late_pulse: got an extra done/err pulse expected none"); end
    repeat (GAP_C) step();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   g;
    logic bad;
    bad = 1'b0;
    bus.req_data[DW-1:0] = 40'hEE_5555_AAAA;
    bus.req_valid = 2'b01;
    #1;
    g = pick(bus.req_valid, ptr_m);
    n_checks++; if (bus.req_ready !== oh(g)) begin n_fail++; $display("FAIL rm_ready: got %b expected %b", bus.req_ready, oh(g)); end
    exp_q.push_back('{data: 40'hEE_5555_AAAA, idx: g});
    step();
    bus.req_valid = 2'b00;
    e = exp_q.pop_front();
    n_checks++; if (bus.shf_data !== e.data) begin n_fail++; $display("FAIL rm_shf_data: got %h expected %h", bus.shf_data, e.data); end
    step(); step(); step();                   // inside WAIT
    reset = 1'b1;
    step();
    n_checks++; if (bus.spi_cs_n !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_abort: got cs_n=%b busy=%b expected 1/0", bus.spi_cs_n, busy); end
    n_checks++; if (bus.req_done !== 2'b00 || bus.req_err !== 2'b00) begin n_fail++; $display("FAIL rm_no_pulse: got done=%b err=%b expected 00/00", bus.req_done, bus.req_err); end
    reset = 1'b0;
    ptr_m = 0;
    bus.req_valid = 2'b11;
    #1;
    g = pick(bus.req_valid, ptr_m);
    n_checks++; if (bus.req_ready !== oh(g)) begin n_fail++; $display("FAIL rm_rr_ptr: got %b expected %b", bus.req_ready, oh(g)); end
    bus.req_valid = 2'b00;
    repeat (3) begin
      step();
      if (bus.req_done !== 2'b00 || bus.req_err !== 2'b00 || busy !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL rm_quiet: got activity after reset expected idle"); end
  endtask

  task automatic test_stray_done();
    exp_t e;
    int   g;
    logic bad;
    bad = 1'b0;
    bus.shf_done = 1'b1;
    step();
    bus.shf_done = 1'b0;
    repeat (2) begin
      if (busy !== 1'b0 || bus.req_done !== 2'b00 || bus.req_err !== 2'b00 || bus.spi_cs_n !== 1'b1) bad = 1'b1;
      step();
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL stray_idle: got activity after idle shf_done expected none"); end
    bus.req_data[DW-1:0] = 40'h12_3456_789A;
    bus.req_valid = 2'b01;
    #1;
    g = pick(bus.req_valid, ptr_m);
    exp_q.push_back('{data: 40'h12_3456_789A, idx: g});
    ptr_m = (g + 1) % NREQ;
    step();
    bus.req_valid = 2'b00;
    e = exp_q.pop_front();
    n_checks++; if (bus.shf_start !== 1'b1 || bus.shf_data !== e.data) begin n_fail++; $display("FAIL stray_setup: got start=%b data=%h expected 1/%h", bus.shf_start, bus.shf_data, e.data); end
    step(); step();
    bus.shf_done = 1'b1;
    step();                                   // D
    bus.shf_done = 1'b0;
    n_checks++; if (bus.req_done !== oh(e.idx)) begin n_fail++; $display("FAIL stray_done: got %b expected %b", bus.req_done, oh(e.idx)); end
    step();                                   // D+1, GAP
    bus.shf_done = 1'b1;
    step();                                   // D+2
    bus.shf_done = 1'b0;
    n_checks++; if (bus.req_done !== 2'b00 || bus.req_err !== 2'b00) begin n_fail++; $display("FAIL stray_gap_pulse: got done=%b err=%b expected 00/00", bus.req_done, bus.req_err); end
    step();                                   // D+3
    n_checks++; if (busy !== 1'b1 || bus.spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL stray_gap_hold: got busy=%b cs_n=%b expected 1/1", busy, bus.spi_cs_n); end
    step();                                   // D+4
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stray_gap_end: got busy=%b expected 0", busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_coincide();
    test_reset_mid();
    test_stray_done();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_arbiter.md
# spi_frame_arbiter

Controller that shares the single 40-bit SPI frame shifter between several requesters. It round-robin arbitrates requests, latches the winning 40-bit frame, and drives chip-select and a start pulse to the shifter. It then waits for the shifter's completion with an 8-bit watchdog, reports done or error to the owner, and enforces a minimum chip-select-high gap between frames. It sits between the command sources and the shifter that generates `spi_sclk`/`spi_data`.

## Interface
- `NUM_REQ`, default 2: number of requesters (2..8).
- `DATA_W`, default 40: frame width; matches the shifter.
- `GAP_CYCLES`, default 4: clocks `spi_cs_n` is held high after each frame (0..255).
- `TIMEOUT`, default 200: WAIT-state clocks before abort (1..255).

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester frame request.
- `req_data`  in  NUM_REQ*DATA_W  frames; requester i occupies bits [i*DATA_W +: DATA_W]; held stable while valid and not ready.
- `req_ready`  out  NUM_REQ  one-hot accept; transfer when valid&ready.
- `req_done`  out  NUM_REQ  one-cycle completion pulse to the owner.
- `req_err`  out  NUM_REQ  one-cycle timeout pulse to the owner.
- `shf_data`  out  DATA_W  frame to the shifter.
- `shf_start`  out  1  one-cycle start pulse to the shifter.
- `shf_done`  in  1  shifter last-bit-complete pulse.
- `spi_cs_n`  out  1  active-low chip select.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SETUP, WAIT, GAP.
- **IDLE** (`spi_cs_n`=1):
  - If any `req_valid` is high, grant g = first valid index at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - `req_ready[g]`=1 in the same cycle. It is combinational from state and `req_valid`; no other ready bit is high.
  - On the clock edge: latch `req_data[g]` into `shf_data`, set `owner`<=g, set `rr_ptr`<=(g+1)%NUM_REQ, go to SETUP.
- **SETUP**, exactly 1 cycle: `spi_cs_n`=0, `shf_start`=1. Then go to WAIT and clear the watchdog to 0.
- **WAIT**: `spi_cs_n`=0. The watchdog increments each cycle.
  - On `shf_done`: go to GAP and pulse `req_done[owner]`.
  - When the watchdog reaches TIMEOUT-1 without `shf_done`: go to GAP and pulse `req_err[owner]`.
  - If `shf_done` and expiry coincide, done wins; no error pulse.
- **GAP**: `spi_cs_n`=1. Count GAP_CYCLES cycles, then go to IDLE. With GAP_CYCLES=0, WAIT goes directly to IDLE.
- `shf_done` is ignored outside WAIT.
- `req_data` is not sampled after acceptance. A requester may drop valid or change data freely once accepted.
- Watchdog and gap counters are 8 bits wide and never wrap in legal operation.

## Timing
- All outputs are registered except `req_ready`.
- Reset values: `req_ready`=0, `req_done`=0, `req_err`=0, `shf_data`=0, `shf_start`=0, `spi_cs_n`=1, `busy`=0. Also state=IDLE, `rr_ptr`=0, `owner`=0, counters=0.
- Cycle sequence from acceptance at cycle T:
  - T+1: SETUP; `spi_cs_n` falls, `shf_start` is high, `shf_data` is valid.
  - T+2: first WAIT cycle.
- `req_done`/`req_err` is high in the cycle after `shf_done` is sampled or the watchdog expires. `spi_cs_n` rises in that same cycle.
- Minimum spacing between frames is GAP_CYCLES+1 cycles with `spi_cs_n` high. The next grant occurs in the first IDLE cycle.
- Reset asserted in any state takes effect at the next edge. There is no done or err pulse, and the in-flight frame is abandoned with `spi_cs_n`=1.

## Structure
- Package `spi_pkg`:
  - `SPI_FRAME_W`=40.
  - State enum `spi_arb_state_t` {IDLE, SETUP, WAIT, GAP}.
  - Default GAP and TIMEOUT constants.
- Sub-module `spi_rr_pick`: purely combinational. Takes `req_valid` and `rr_ptr`; returns a one-hot grant and its index, plus an any-valid flag.
- Top module: FSM, counters, frame register, output registers.

## Test plan
1. **Single request.** req_valid[0] with data 40'hA5_1234_5678 at cycle 0. Expect:
   - ready[0] at cycle 0.
   - cs_n low and shf_start high at cycle 1, with shf_data=40'hA5_1234_5678.
   - shf_done at cycle 45 → req_done[0] at cycle 46, cs_n high at cycle 46.
   - Returns to IDLE at cycle 50 (GAP=4).
2. **Fairness.** Both requesters are held valid continuously. Expect grants in order 0,1,0,1. Each grant is separated by at least 5 cs_n-high cycles.
3. **Timeout.** shf_done is never asserted (TIMEOUT=200). Expect req_err[owner] exactly 200 cycles after entering WAIT, no req_done, then cs_n high.
4. **Coincidence.** shf_done arrives on the watchdog's final cycle. Expect req_done only.
5. **Reset mid-frame.** Assert reset during WAIT. Expect state IDLE, cs_n=1, rr_ptr=0 after one edge, with no done or err pulse.
6. **Stray done.** shf_done is pulsed in IDLE and in GAP. Expect no state change and no pulses.
